dct_row_result_streamer: RTL and testbench

- Reader for the 8-row vector-matrix product array (eight parallel sequential MAC rows sharing one start/done).
- Detects completion on the shared done and captures all eight row results Y0..Y7 in one cycle.
- Streams the captured words one per beat over a valid/ready interface to the next Y = D·X·Dᵀ stage (transpose buffer or second pass).
- Frees the array for its next start while the previous result drains.

---
 rtl/dct_row_result_streamer.sv | 90 +++++++++
 tb/tb_dct_row_result_streamer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dct_row_result_streamer.sv
// dct_row_result_streamer: captures the eight row results on a done rise and streams them as valid/ready beats.
// Optional DCT_STREAM_SAT_OUT_EN: signed saturation of each word to OW bits, with m_sat flagging clamped words.
module dct_row_result_streamer #(
   parameter int N  = 8,
   parameter int OW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             done_in,
   input  logic [2*N+2:0]   y0,
   input  logic [2*N+2:0]   y1,
   input  logic [2*N+2:0]   y2,
   input  logic [2*N+2:0]   y3,
   input  logic [2*N+2:0]   y4,
   input  logic [2*N+2:0]   y5,
   input  logic [2*N+2:0]   y6,
   input  logic [2*N+2:0]   y7,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OW-1:0]    m_data,
   output logic [2:0]       m_idx,
   output logic             m_last,
   output logic             m_sat,
   output logic             busy,
   output logic             ovf
);
   localparam int YW = 2*N+3;
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic done_prev_q, ovf_q, ovf_d, load, cap_evt, beat, final_beat;
   logic [YW-1:0] bank_q [8];
   logic [YW-1:0] ys [8];
   logic [YW-1:0] word;
   assign ys = '{y0, y1, y2, y3, y4, y5, y6, y7};
   assign cap_evt = done_in & ~done_prev_q;
   assign m_valid = state_q == STREAM;
   assign beat = m_valid & m_ready;
   assign final_beat = beat & (idx_q == 3'd7);
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      ovf_d = ovf_q | (cap_evt & m_valid & ~final_beat);
      load = cap_evt & (~m_valid | final_beat);
      if (load) begin
         state_d = STREAM;
         idx_d = 3'd0;
      end else if (final_beat) begin
         state_d = IDLE;
         idx_d = 3'd0;
      end else if (beat) begin
         idx_d = idx_q + 3'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= 3'd0;
         ovf_q <= 1'b0;
         done_prev_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         ovf_q <= ovf_d;
         done_prev_q <= done_in;
      end
   end
   always_ff @(posedge clk) begin
      if (load) bank_q <= ys;
   end
   assign word = bank_q[idx_q];
   assign m_idx = idx_q;
   assign m_last = m_valid & (idx_q == 3'd7);
   assign busy = m_valid;
   assign ovf = ovf_q;
`ifdef DCT_STREAM_SAT_OUT_EN
   // The word fits iff every bit from the OW-bit sign position upward matches.
   logic [YW-OW:0] hi;
   logic clamp;
   assign hi = word[YW-1:OW-1];
   assign clamp = ~(&hi | ~|hi);
   assign m_data = clamp ? {word[YW-1], {(OW-1){~word[YW-1]}}} : word[OW-1:0];
   assign m_sat = m_valid & clamp;
`else
   logic unused_hi;
   assign unused_hi = ^word;
   assign m_data = word[OW-1:0];
   assign m_sat = 1'b0;
`endif
endmodule

// File: tb/tb_dct_row_result_streamer.sv
// tb_dct_row_result_streamer: directed and random stimulus against a queue-based model of the result stream.
module tb_dct_row_result_streamer;
   localparam int N = 8, OW = 16, YW = 2*N+3;
   logic clk = 1'b0, rst, done_in, m_ready;
   logic [YW-1:0] y [8];
   logic m_valid, m_last, m_sat, busy, ovf;
   logic [OW-1:0] m_data;
   logic [2:0] m_idx;
   int tests = 0, fails = 0;
   logic [YW-1:0] qw[$];
   logic [2:0] qi[$];
   logic mp = 1'b1, movf = 1'b0;

   always #5 clk = ~clk;

   dct_row_result_streamer #(.N(N), .OW(OW)) dut (
      .clk(clk), .rst(rst), .done_in(done_in),
      .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]), .y4(y[4]), .y5(y[5]), .y6(y[6]), .y7(y[7]),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
      .m_last(m_last), .m_sat(m_sat), .busy(busy), .ovf(ovf));

   function automatic logic is_clamped(logic [YW-1:0] w);
      longint v = $signed(w);
      longint lim = 64'sd1 <<< (OW-1);
`ifdef DCT_STREAM_SAT_OUT_EN
      return (v > lim - 1) || (v < -lim);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [OW-1:0] fmt(logic [YW-1:0] w);
      longint v = $signed(w);
      longint lim = 64'sd1 <<< (OW-1);
      if (is_clamped(w)) return (v > 0) ? OW'(lim - 1) : OW'(-lim);
      return w[OW-1:0];
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      int n0;
      bit cap, bt;
      @(negedge clk);
      chk("m_valid", {31'd0, m_valid}, {31'd0, qw.size() > 0});
      chk("busy", {31'd0, busy}, {31'd0, qw.size() > 0});
      chk("ovf", {31'd0, ovf}, {31'd0, movf});
      if (qw.size() > 0) begin
         chk("m_data", 32'(m_data), 32'(fmt(qw[0])));
         chk("m_idx", 32'(m_idx), 32'(qi[0]));
         chk("m_last", {31'd0, m_last}, {31'd0, qi[0] == 3'd7});
         chk("m_sat", {31'd0, m_sat}, {31'd0, is_clamped(qw[0])});
      end
      @(posedge clk);
      #1;
      if (rst) begin
         qw.delete();
         qi.delete();
         movf = 1'b0;
         mp = 1'b1;
      end else begin
         n0 = qw.size();
         cap = done_in && !mp;
         bt = n0 > 0 && m_ready;
         if (bt) begin
            void'(qw.pop_front());
            void'(qi.pop_front());
         end
         if (cap) begin
            if (n0 == 0 || (n0 == 1 && bt)) begin
               for (int k = 0; k < 8; k++) begin
                  qw.push_back(y[k]);
                  qi.push_back(3'(k));
               end
            end else movf = 1'b1;
         end
         mp = done_in;
      end
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic rand_y();
      for (int k = 0; k < 8; k++) y[k] = YW'($urandom);
   endtask

   initial begin
      rst = 1'b1;
      done_in = 1'b1;
      m_ready = 1'b0;
      for (int k = 0; k < 8; k++) y[k] = YW'(100 + k);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run(4);
      done_in = 1'b0;
      run(1);
      m_ready = 1'b1;
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(10);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      for (int c = 0; c < 30; c++) begin
         m_ready = (c % 3 == 0);
         run(1);
      end
      m_ready = 1'b1;
      run(3);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(7);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(10);
      chk("ovf_after_b2b", {31'd0, ovf}, 32'd0);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(3);
      m_ready = 1'b0;
      run(1);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(2);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      m_ready = 1'b1;
      run(10);
      rand_y();
      y[3] = 19'h10000;
      y[5] = 19'h70000;
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(10);
      for (int c = 0; c < 400; c++) begin
         done_in = ($urandom_range(0, 3) == 0);
         m_ready = $urandom_range(0, 1) == 1;
         rand_y();
         run(1);
      end
      done_in = 1'b0;
      m_ready = 1'b1;
      run(20);
      rand_y();
      done_in = 1'b1;
      run(1);
      done_in = 1'b0;
      run(3);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      chk("rst_idx", 32'(m_idx), 32'd0);
      run(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
